// File: rtl/demux_router_pkg.sv
// demux_router_pkg: sizes shared by the demux, mux and FIFO blocks of the link.
// Latency: n/a (constants and a decode helper only).
// Backpressure: n/a.
package demux_router_pkg;

  // Channel fan-out and the selector width needed to address it.
  localparam int NUM_CH   = 4;
  localparam int SEL_BITS = 2;

  // Default widths; each block may override them through its parameters.
  localparam int DATA_BITS_DEF = 4;
  localparam int CNT_BITS_DEF  = 8;

  // One-hot decode of a channel selector.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_BITS-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_router_canal.sv
// demux_canal: one output channel register of the demux with load/drain control.
// Latency: a word loaded at edge N is presented in cycle N+1.
// Backpressure: holds dout/valid while pausa=1; libre tells the top a load is safe.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         write din into the channel on this edge (only when libre=1)
//   din          word to store
//   pausa        downstream cannot take the word this cycle
//   dout         registered channel data
//   valid        the register holds an undelivered word
//   libre        channel can accept a word this edge (empty or draining)
module demux_canal
  import demux_router_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pausa,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 libre
);

  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;

  // A load takes priority over a drain so a word arriving while the old one
  // leaves keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_dout  <= din;
      r_valid <= 1'b1;
    end else if (r_valid && !pausa) begin
      // Drain: data is left as-is, only the valid flag clears.
      r_valid <= 1'b0;
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign libre = !r_valid || !pausa;

endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1:4 demux steering one word per cycle to a channel register.
// Latency: one cycle from accept edge to salidaK/validK.
// Backpressure: entrada_ready follows only the addressed channel; paused channels hold.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   enb                      block enable; low blocks new accepts, drains continue
//   entrada, entrada_valid   input word and its valid
//   selector                 destination channel 0..3
//   entrada_ready            combinational accept indication for the addressed channel
//   salida0..3, valid0..3    registered channel data and valid
//   pausa0..3                per-channel downstream stall
//   contador                 wrap-around count of accepted words
module demux_router
  import demux_router_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enb,
  input  logic [DATA_BITS-1:0] entrada,
  input  logic                 entrada_valid,
  input  logic [SEL_BITS-1:0]  selector,
  output logic                 entrada_ready,
  output logic [DATA_BITS-1:0] salida0,
  output logic [DATA_BITS-1:0] salida1,
  output logic [DATA_BITS-1:0] salida2,
  output logic [DATA_BITS-1:0] salida3,
  output logic                 valid0,
  output logic                 valid1,
  output logic                 valid2,
  output logic                 valid3,
  input  logic                 pausa0,
  input  logic                 pausa1,
  input  logic                 pausa2,
  input  logic                 pausa3,
  output logic [CNT_BITS-1:0]  contador
);

  logic [NUM_CH-1:0]    w_pausa;
  logic [NUM_CH-1:0]    w_libre;
  logic [NUM_CH-1:0]    w_valid;
  logic [NUM_CH-1:0]    w_load;
  logic [DATA_BITS-1:0] w_dout [NUM_CH];
  logic                 w_accept;
  logic [CNT_BITS-1:0]  r_contador;

  assign w_pausa = {pausa3, pausa2, pausa1, pausa0};

  // Ready looks only at the addressed channel, so a stalled neighbour never
  // blocks traffic headed elsewhere.
  assign entrada_ready = enb && w_libre[selector];
  assign w_accept      = entrada_valid && entrada_ready;
  assign w_load        = w_accept ? sel_decode(selector) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
    demux_canal #(
      .DATA_BITS (DATA_BITS)
    ) u_canal (
      .clk   (clk),
      .reset (reset),
      .load  (w_load[g]),
      .din   (entrada),
      .pausa (w_pausa[g]),
      .dout  (w_dout[g]),
      .valid (w_valid[g]),
      .libre (w_libre[g])
    );
  end

  // Accepted-word statistics; wraps silently at 2^CNT_BITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_contador <= '0;
    end else if (w_accept) begin
      r_contador <= r_contador + CNT_BITS'(1);
    end
  end

  assign contador = r_contador;
  assign salida0  = w_dout[0];
  assign salida1  = w_dout[1];
  assign salida2  = w_dout[2];
  assign salida3  = w_dout[3];
  assign valid0   = w_valid[0];
  assign valid1   = w_valid[1];
  assign valid2   = w_valid[2];
  assign valid3   = w_valid[3];

endmodule
